// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alarm_pkg
// Purpose  : Shared state encodings and timer interval codes for the car alarm.
// Revision : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_ARMED       = 3'd0,
        ST_TRIGGERED   = 3'd1,
        ST_SOUND_ALARM = 3'd2,
        ST_ALARM_HOLD  = 3'd3,
        ST_DISARMED    = 3'd4,
        ST_WAIT_OPEN   = 3'd5,
        ST_WAIT_CLOSE  = 3'd6,
        ST_ARM_DELAY   = 3'd7
    } state_t;

    // Codes understood by time_parameters when selecting the interval to load.
    typedef enum logic [1:0] {
        SEL_ARM_DELAY       = 2'd0,
        SEL_DRIVER_DELAY    = 2'd1,
        SEL_PASSENGER_DELAY = 2'd2,
        SEL_ALARM_ON        = 2'd3
    } interval_t;

    localparam int c_exp_blank_default = 2;

endpackage : alarm_pkg
`default_nettype wire

// File: rtl/alarm_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : alarm_fsm_if
// Purpose  : Control/status link between the alarm FSM and the interval timer.
// Revision : 1.0 - initial release
// ============================================================================
interface alarm_fsm_if;
    import alarm_pkg::*;

    interval_t interval_sel;
    logic      start_timer;
    logic      expired;
    logic      one_hz_enable;

    modport master (
        output interval_sel,
        output start_timer,
        input  expired,
        input  one_hz_enable
    );

    modport slave (
        input  interval_sel,
        input  start_timer,
        output expired,
        output one_hz_enable
    );

endinterface : alarm_fsm_if
`default_nettype wire

// File: rtl/timer_launch.sv
`default_nettype none
// ============================================================================
// Module   : timer_launch
// Purpose  : Timer launch registers plus expired blanking after each launch.
// Revision : 1.0 - initial release
// ============================================================================
module timer_launch
    import alarm_pkg::*;
#(
    parameter int EXP_BLANK = c_exp_blank_default
) (
    input  wire       clock,
    input  wire       reset,
    input  wire       i_launch,
    input  interval_t i_launch_sel,
    input  wire       i_clear,
    input  wire       i_expired,
    output interval_t o_interval_sel,
    output logic      o_start_timer,
    output logic      o_expired_valid
);

    localparam int c_cnt_w = (EXP_BLANK > 1) ? $clog2(EXP_BLANK + 1) : 1;

    interval_t          r_interval_sel;
    logic               r_start_timer;
    logic [c_cnt_w-1:0] r_blank_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_interval_sel <= SEL_ARM_DELAY;
            r_start_timer  <= 1'b0;
            r_blank_cnt    <= '0;
        end else begin
            r_start_timer <= i_launch;
            if (i_launch) begin
                r_interval_sel <= i_launch_sel;
                r_blank_cnt    <= c_cnt_w'(EXP_BLANK);
            end else if (i_clear) begin
                r_blank_cnt <= '0;
            end else if (r_blank_cnt != '0) begin
                r_blank_cnt <= r_blank_cnt - 1'b1;
            end
        end
    end

    // The timer reports expired while idle, so it is trusted only once the
    // freshly launched count has had time to load.
    assign o_expired_valid = i_expired && (r_blank_cnt == '0) && !r_start_timer;
    assign o_interval_sel  = r_interval_sel;
    assign o_start_timer   = r_start_timer;

endmodule : timer_launch
`default_nettype wire

// File: rtl/alarm_fsm.sv
`default_nettype none
// ============================================================================
// Module   : alarm_fsm
// Purpose  : Main control FSM of the anti-theft car alarm.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_fsm
    import alarm_pkg::*;
#(
    parameter int EXP_BLANK = c_exp_blank_default
) (
    input  wire         clock,
    input  wire         reset,
    input  wire         ignition,
    input  wire         driver_door,
    input  wire         passenger_door,
    input  wire         reprogram,
    alarm_fsm_if.master tmr,
    output logic        siren_enable,
    output logic        status_led
);

    state_t    r_state;
    state_t    w_next_state;
    logic      r_siren;
    logic      r_led;
    logic      w_siren_next;
    logic      w_led_next;
    logic      w_launch;
    logic      w_clear;
    interval_t w_launch_sel;
    logic      w_expired_valid;

    timer_launch #(
        .EXP_BLANK (EXP_BLANK)
    ) u_timer_launch (
        .clock           (clock),
        .reset           (reset),
        .i_launch        (w_launch),
        .i_launch_sel    (w_launch_sel),
        .i_clear         (w_clear),
        .i_expired       (tmr.expired),
        .o_interval_sel  (tmr.interval_sel),
        .o_start_timer   (tmr.start_timer),
        .o_expired_valid (w_expired_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_ARMED;
            r_siren <= 1'b0;
            r_led   <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_siren <= w_siren_next;
            r_led   <= w_led_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        w_launch_sel = SEL_ARM_DELAY;
        w_clear      = 1'b0;
        if (reprogram) begin
            w_next_state = ST_ARMED;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (driver_door) begin
                        w_next_state = ST_TRIGGERED;
                        w_launch     = 1'b1;
                        w_launch_sel = SEL_DRIVER_DELAY;
                    end else if (passenger_door) begin
                        w_next_state = ST_TRIGGERED;
                        w_launch     = 1'b1;
                        w_launch_sel = SEL_PASSENGER_DELAY;
                    end
                end
                ST_TRIGGERED: begin
                    if (ignition)             w_next_state = ST_DISARMED;
                    else if (w_expired_valid) w_next_state = ST_SOUND_ALARM;
                end
                ST_SOUND_ALARM: begin
                    if (ignition) begin
                        w_next_state = ST_DISARMED;
                    end else if (!driver_door && !passenger_door) begin
                        w_next_state = ST_ALARM_HOLD;
                        w_launch     = 1'b1;
                        w_launch_sel = SEL_ALARM_ON;
                    end
                end
                ST_ALARM_HOLD: begin
                    if (ignition)                        w_next_state = ST_DISARMED;
                    else if (driver_door || passenger_door) w_next_state = ST_SOUND_ALARM;
                    else if (w_expired_valid)            w_next_state = ST_ARMED;
                end
                ST_DISARMED: begin
                    if (!ignition) w_next_state = ST_WAIT_OPEN;
                end
                ST_WAIT_OPEN: begin
                    if (ignition)         w_next_state = ST_DISARMED;
                    else if (driver_door) w_next_state = ST_WAIT_CLOSE;
                end
                ST_WAIT_CLOSE: begin
                    if (ignition) begin
                        w_next_state = ST_DISARMED;
                    end else if (!driver_door) begin
                        w_next_state = ST_ARM_DELAY;
                        w_launch     = 1'b1;
                        w_launch_sel = SEL_ARM_DELAY;
                    end
                end
                ST_ARM_DELAY: begin
                    if (ignition)             w_next_state = ST_DISARMED;
                    else if (driver_door)     w_next_state = ST_WAIT_CLOSE;
                    else if (w_expired_valid) w_next_state = ST_ARMED;
                end
                default: w_next_state = ST_ARMED;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the entry edge.
    always_comb begin
        w_siren_next = (w_next_state == ST_SOUND_ALARM) || (w_next_state == ST_ALARM_HOLD);
        w_led_next   = r_led;
        case (w_next_state)
            ST_ARMED, ST_SOUND_ALARM: w_led_next = 1'b1;
            ST_DISARMED:              w_led_next = 1'b0;
            ST_TRIGGERED, ST_ARM_DELAY: begin
                if ((w_next_state == r_state) && tmr.one_hz_enable) w_led_next = ~r_led;
            end
            default: w_led_next = r_led;
        endcase
    end

    assign siren_enable = r_siren;
    assign status_led   = r_led;

endmodule : alarm_fsm
`default_nettype wire

// File: doc/alarm_fsm.md
Name: alarm_fsm

Overview:
- Main control FSM of the anti-theft car alarm; sits directly upstream of timer.
- Decides which interval timer runs, drives interval_sel to time_parameters (which returns the 4-bit value to timer), and pulses start_timer.
- Consumes timer's expired and one_hz_enable.
- Drives siren_enable (to siren, which also takes half_hz_enable) and status_led.

Parameters:
EXP_BLANK, 2, cycles after a start_timer pulse (pulse cycle included) during which expired is ignored; covers timer load latency, since timer holds expired high while idle.

Ports:
clock  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high; one clock; all registers reset on the clock edge where reset=1
ignition  input  1  ignition switch, 1=on; debounced and synchronised upstream
driver_door  input  1  1=driver door open; debounced and synchronised
passenger_door  input  1  1=any passenger door open; debounced and synchronised
reprogram  input  1  level from time_parameters; 1=parameters being rewritten
expired  input  1  from timer
one_hz_enable  input  1  from timer; 1-cycle tick while timer counts
interval_sel  output  2  to time_parameters: ARM_DELAY=0, DRIVER_DELAY=1, PASSENGER_DELAY=2, ALARM_ON=3
start_timer  output  1  to timer; 1-cycle pulse
siren_enable  output  1  to siren
status_led  output  1  status indicator

Behaviour:
- All outputs are registered.
- Reset values: state=ARMED, interval_sel=0, start_timer=0, siren_enable=0, status_led=1, blank counter=0.
- Timer launch: every transition that starts the timer sets interval_sel and start_timer=1 on the same edge. interval_sel then holds until the next launch. start_timer returns to 0 on the following edge.
- Expired blanking: a launch loads the blank counter with EXP_BLANK; it decrements per cycle. expired is acted on only when the counter is 0 and start_timer=0.
- States are 3-bit encoded.
- ARMED: status_led=1, siren off.
  - driver_door=1 -> TRIGGERED, launch DRIVER_DELAY. Driver wins if both doors open in the same cycle.
  - else passenger_door=1 -> TRIGGERED, launch PASSENGER_DELAY.
  - ignition is ignored in this state.
- TRIGGERED:
  - status_led toggles on each one_hz_enable.
  - ignition=1 -> DISARMED; has priority over expired in the same cycle.
  - else valid expired -> SOUND_ALARM.
- SOUND_ALARM: siren_enable=1, status_led=1.
  - ignition=1 -> DISARMED.
  - else both doors closed -> ALARM_HOLD, launch ALARM_ON.
- ALARM_HOLD: siren_enable=1.
  - ignition=1 -> DISARMED.
  - else any door open -> SOUND_ALARM.
  - else valid expired -> ARMED.
- DISARMED: siren 0, status_led 0.
  - ignition=0 -> WAIT_OPEN.
- WAIT_OPEN:
  - ignition=1 -> DISARMED.
  - else driver_door=1 -> WAIT_CLOSE.
- WAIT_CLOSE:
  - ignition=1 -> DISARMED.
  - else driver_door=0 -> ARM_DELAY, launch ARM_DELAY.
- ARM_DELAY: status_led toggles on one_hz_enable.
  - ignition=1 -> DISARMED.
  - else driver_door=1 -> WAIT_CLOSE; the timer keeps running and its result is ignored.
  - else valid expired -> ARMED.
- Priority within a state, highest first: reprogram, then ignition, then door events, then expired.
- Leaving a timed state without expiry leaves the timer running. The FSM ignores the stale expiry because any new timed state launches afresh.
- reprogram=1 in any state -> ARMED:
  - no launch; siren_enable=0, status_led=1, blank counter cleared.
  - held while reprogram=1; FSM leaves ARMED only after reprogram returns to 0.
- Entering SOUND_ALARM or DISARMED drives siren_enable from the next-state value, with no extra cycle.
- Illegal state encodings -> ARMED on the next edge.
- Reset mid-operation: returns to the reset values on the next edge. No start_timer pulse is emitted on the reset edge.

Decomposition:
- Shared package alarm_pkg holds:
  - state encodings (ARMED, TRIGGERED, SOUND_ALARM, ALARM_HOLD, DISARMED, WAIT_OPEN, WAIT_CLOSE, ARM_DELAY);
  - interval_sel codes 0..3, used by time_parameters.
- One natural sub-module, timer_launch: holds the interval_sel/start_timer registers plus the EXP_BLANK counter, and exposes expired_valid.

Test Plan:
- Reset, then driver_door=1 at cycle 5 -> cycle 6: start_timer=1 and interval_sel=1 for exactly one cycle. expired still high at cycles 6-7 causes no transition. Timer expiry later -> SOUND_ALARM, siren_enable=1.
- ARMED, both doors open in the same cycle -> interval_sel=1 (driver priority). passenger only -> interval_sel=2.
- TRIGGERED, ignition=1 in the same cycle expired becomes valid -> DISARMED, siren_enable=0, status_led=0.
- SOUND_ALARM, doors close -> launch interval_sel=3. Door reopens before expiry -> SOUND_ALARM. Close again -> fresh launch, expiry -> ARMED, siren 0.
- DISARMED, ignition off, driver open/close -> launch interval_sel=0. Reopen and close -> second launch. Expiry -> ARMED, status_led=1.
- reprogram=1 during SOUND_ALARM -> next edge ARMED, siren 0, no start_timer. Held reprogram with door open -> stays ARMED until released.
